// File: rtl/pc_unit_pkg.sv
// Fetch-PC shared definitions: default width, reset/trap vectors and next-PC source codes.
// The return-address stack is built in only when PC_RAS_EN is defined.
package pc_unit_pkg;

    localparam int          PC_AW_DEF   = 32;
    localparam logic [31:0] PC_RST_VEC  = 32'h0000_0000;
    localparam logic [31:0] PC_TRAP_VEC = 32'h0000_0080;

`ifdef PC_RAS_EN
    localparam bit PC_RAS_ON = 1'b1;
`else
    localparam bit PC_RAS_ON = 1'b0;
`endif

    typedef enum logic [2:0] {
        SRC_TRAP,
        SRC_HOLD,
        SRC_RET,
        SRC_JUMP,
        SRC_BRANCH,
        SRC_SEQ
    } pc_src_e;

endpackage

// File: rtl/pc_ras.sv
// Circular return-address stack with push, pop, replace-top and clear; a push when full overwrites the oldest entry.
// Updates on the same clk edge as the PC; o_underflow is a registered one-cycle pulse.
module pc_ras #(
    parameter int AW    = 32,
    parameter int DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    i_push,
    input  logic                    i_pop,
    input  logic                    i_clear,
    input  logic [AW-1:0]           i_push_dat,
    output logic [AW-1:0]           o_top,
    output logic [$clog2(DEPTH):0]  o_count,
    output logic                    o_underflow
);

    localparam int          PW   = $clog2(DEPTH);
    localparam logic [PW:0] FULL = (PW+1)'(DEPTH);
    localparam logic [PW:0] ONE  = (PW+1)'(1);

    logic [AW-1:0] r_mem [DEPTH];
    logic [PW-1:0] r_wp;
    logic [PW:0]   r_count;
    logic          r_underflow;

    logic [PW-1:0] w_top_idx;
    logic          w_empty;
    logic          w_replace;
    logic          w_pop;
    logic          w_push;

    assign w_top_idx = r_wp - PW'(1);
    assign w_empty   = (r_count == '0);
    // call+ret on a live stack swaps the top instead of pop-then-push
    assign w_replace = i_push & i_pop & ~w_empty;
    assign w_pop     = i_pop & ~i_push & ~w_empty;
    assign w_push    = i_push & ~w_replace;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wp        <= '0;
            r_count     <= '0;
            r_underflow <= 1'b0;
        end else begin
            r_underflow <= i_pop & w_empty & ~i_clear;
            if (i_clear) begin
                r_count <= '0;
            end else if (w_pop) begin
                r_wp    <= w_top_idx;
                r_count <= r_count - ONE;
            end else if (w_push) begin
                r_wp <= r_wp + PW'(1);
                if (r_count != FULL)
                    r_count <= r_count + ONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!i_clear) begin
            if (w_replace)
                r_mem[w_top_idx] <= i_push_dat;
            else if (w_push)
                r_mem[r_wp] <= i_push_dat;
        end
    end

    assign o_top       = r_mem[w_top_idx];
    assign o_count     = r_count;
    assign o_underflow = r_underflow;

endmodule

// File: rtl/pc_unit.sv
// Fetch program counter: next PC from trap > stall > ret > jump > branch > step; RAS present only with PC_RAS_EN.
// One-cycle redirect latency; i_stall holds the PC, i_trap overrides it.
module pc_unit
    import pc_unit_pkg::*;
#(
    parameter int            AW        = PC_AW_DEF,
    parameter int            STEP      = 1,
    parameter logic [AW-1:0] RST_VEC   = AW'(PC_RST_VEC),
    parameter logic [AW-1:0] TRAP_VEC  = AW'(PC_TRAP_VEC),
    parameter int            RAS_DEPTH = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        i_stall,
    input  logic                        i_trap,
    input  logic                        i_jump_valid,
    input  logic [AW-1:0]               i_jump_target,
    input  logic                        i_branch_valid,
    input  logic [AW-1:0]               i_branch_off,
    input  logic                        i_call,
    input  logic                        i_ret,
    output logic [AW-1:0]               o_pc,
    output logic [AW-1:0]               o_pc_next,
    output logic [$clog2(RAS_DEPTH):0]  o_ras_count,
    output logic                        o_ras_underflow
);

    logic [AW-1:0] r_pc;
    logic [AW-1:0] w_pc_next;
    logic [AW-1:0] w_pc_step;
    logic [AW-1:0] w_ras_top;
    logic          w_ras_vld;
    pc_src_e       w_src;

    assign w_pc_step = r_pc + AW'(STEP);

`ifdef PC_RAS_EN
    logic [$clog2(RAS_DEPTH):0] w_ras_count;
    logic                       w_live;

    assign w_live = ~i_stall & ~i_trap;

    pc_ras #(
        .AW    (AW),
        .DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk         (clk),
        .rst         (rst),
        .i_push      (w_live & i_call & i_jump_valid),
        .i_pop       (w_live & i_ret),
        .i_clear     (i_trap),
        .i_push_dat  (w_pc_step),
        .o_top       (w_ras_top),
        .o_count     (w_ras_count),
        .o_underflow (o_ras_underflow)
    );

    assign w_ras_vld   = PC_RAS_ON & i_ret & (w_ras_count != '0);
    assign o_ras_count = w_ras_count;
`else
    logic w_unused_ras;

    assign w_unused_ras    = i_call ^ i_ret;
    assign w_ras_top       = '0;
    assign w_ras_vld       = 1'b0;
    assign o_ras_count     = '0;
    assign o_ras_underflow = 1'b0;
`endif

    always_comb begin
        w_src = SRC_SEQ;
        if (i_trap)
            w_src = SRC_TRAP;
        else if (i_stall)
            w_src = SRC_HOLD;
        else if (w_ras_vld)
            w_src = SRC_RET;
        else if (i_jump_valid)
            w_src = SRC_JUMP;
        else if (i_branch_valid)
            w_src = SRC_BRANCH;
    end

    always_comb begin
        w_pc_next = w_pc_step;
        case (w_src)
            SRC_TRAP:   w_pc_next = TRAP_VEC;
            SRC_HOLD:   w_pc_next = r_pc;
            SRC_RET:    w_pc_next = w_ras_top;
            SRC_JUMP:   w_pc_next = i_jump_target;
            SRC_BRANCH: w_pc_next = r_pc + i_branch_off;
            default:    w_pc_next = w_pc_step;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_pc <= RST_VEC;
        else
            r_pc <= w_pc_next;
    end

    assign o_pc      = r_pc;
    assign o_pc_next = w_pc_next;

endmodule

// File: tb/tb_pc_unit.sv
// Three pc_unit instances (32b/step4, 8b/step1, 16b/step1) on shared stimulus, checked every cycle
// against a list-based model, plus directed scenarios with literal expected values.
module tb_pc_unit;

`ifdef PC_RAS_EN
    localparam bit RAS_EN = 1'b1;
`else
    localparam bit RAS_EN = 1'b0;
`endif

    localparam logic [31:0] MASK  [3] = '{32'hFFFF_FFFF, 32'h0000_00FF, 32'h0000_FFFF};
    localparam int          STEPS [3] = '{4, 1, 1};

    logic        clk;
    logic        rst, stall, trap, jv, bv, call, ret;
    logic [31:0] jt, bo;

    logic [31:0] pc_a, pcn_a;
    logic [7:0]  pc_b, pcn_b;
    logic [15:0] pc_c, pcn_c;
    logic [2:0]  cnt_a, cnt_b, cnt_c;
    logic        uf_a, uf_b, uf_c;

    logic [31:0] dut_pc [3];
    logic [31:0] dut_pcn[3];
    logic [2:0]  dut_cnt[3];
    logic        dut_uf [3];

    // model state: stack kept as an ordered list, oldest at index 0
    logic [31:0] m_pc [3] = '{32'h0, 32'h0, 32'h0};
    logic [31:0] m_stk[3][4];
    int          m_cnt[3] = '{0, 0, 0};
    logic        m_uf [3] = '{1'b0, 1'b0, 1'b0};

    int n_tests = 0;
    int n_fail  = 0;

    pc_unit #(.AW(32), .STEP(4), .RAS_DEPTH(4)) u_dut_a (
        .clk(clk), .rst(rst), .i_stall(stall), .i_trap(trap),
        .i_jump_valid(jv), .i_jump_target(jt),
        .i_branch_valid(bv), .i_branch_off(bo),
        .i_call(call), .i_ret(ret),
        .o_pc(pc_a), .o_pc_next(pcn_a), .o_ras_count(cnt_a), .o_ras_underflow(uf_a)
    );

    pc_unit #(.AW(8), .STEP(1), .RAS_DEPTH(4)) u_dut_b (
        .clk(clk), .rst(rst), .i_stall(stall), .i_trap(trap),
        .i_jump_valid(jv), .i_jump_target(jt[7:0]),
        .i_branch_valid(bv), .i_branch_off(bo[7:0]),
        .i_call(call), .i_ret(ret),
        .o_pc(pc_b), .o_pc_next(pcn_b), .o_ras_count(cnt_b), .o_ras_underflow(uf_b)
    );

    pc_unit #(.AW(16), .STEP(1), .RAS_DEPTH(4)) u_dut_c (
        .clk(clk), .rst(rst), .i_stall(stall), .i_trap(trap),
        .i_jump_valid(jv), .i_jump_target(jt[15:0]),
        .i_branch_valid(bv), .i_branch_off(bo[15:0]),
        .i_call(call), .i_ret(ret),
        .o_pc(pc_c), .o_pc_next(pcn_c), .o_ras_count(cnt_c), .o_ras_underflow(uf_c)
    );

    always_comb begin
        dut_pc[0]  = pc_a;         dut_pc[1]  = 32'(pc_b);  dut_pc[2]  = 32'(pc_c);
        dut_pcn[0] = pcn_a;        dut_pcn[1] = 32'(pcn_b); dut_pcn[2] = 32'(pcn_c);
        dut_cnt[0] = cnt_a;        dut_cnt[1] = cnt_b;      dut_cnt[2] = cnt_c;
        dut_uf[0]  = uf_a;         dut_uf[1]  = uf_b;       dut_uf[2]  = uf_c;
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] model_next(int k);
        if (trap)                          return 32'h80 & MASK[k];
        if (stall)                         return m_pc[k];
        if (RAS_EN && ret && m_cnt[k] > 0) return m_stk[k][m_cnt[k]-1];
        if (jv)                            return jt & MASK[k];
        if (bv)                            return (m_pc[k] + bo) & MASK[k];
        return (m_pc[k] + 32'(STEPS[k])) & MASK[k];
    endfunction

    task automatic model_edge();
        for (int k = 0; k < 3; k++) begin
            logic [31:0] nxt;
            logic [31:0] ra;
            bit          push;
            bit          pop;
            nxt  = model_next(k);
            ra   = (m_pc[k] + 32'(STEPS[k])) & MASK[k];
            push = RAS_EN && !stall && !trap && call && jv;
            pop  = RAS_EN && !stall && !trap && ret;
            m_uf[k] = pop && (m_cnt[k] == 0);
            if (trap) begin
                m_cnt[k] = 0;
            end else if (pop && m_cnt[k] > 0 && push) begin
                m_stk[k][m_cnt[k]-1] = ra;
            end else if (pop && m_cnt[k] > 0) begin
                m_cnt[k] = m_cnt[k] - 1;
            end else if (push) begin
                if (m_cnt[k] == 4) begin
                    for (int j = 0; j < 3; j++) m_stk[k][j] = m_stk[k][j+1];
                    m_stk[k][3] = ra;
                end else begin
                    m_stk[k][m_cnt[k]] = ra;
                    m_cnt[k] = m_cnt[k] + 1;
                end
            end
            m_pc[k] = nxt;
        end
    endtask

    initial begin
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                for (int k = 0; k < 3; k++) begin
                    m_pc[k] = 32'h0; m_cnt[k] = 0; m_uf[k] = 1'b0;
                end
            end else begin
                model_edge();
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            for (int k = 0; k < 3; k++) begin
                chk($sformatf("pc[%0d]", k),        dut_pc[k],           m_pc[k]);
                chk($sformatf("pc_next[%0d]", k),   dut_pcn[k],          model_next(k));
                chk($sformatf("ras_count[%0d]", k), 32'(dut_cnt[k]),     32'(m_cnt[k]));
                chk($sformatf("underflow[%0d]", k), 32'(dut_uf[k]),      32'(m_uf[k]));
            end
        end
    end

    task automatic tick();
        @(negedge clk);
        #2;
    endtask

    task automatic idle();
        stall = 0; trap = 0; jv = 0; bv = 0; call = 0; ret = 0; jt = 0; bo = 0;
    endtask

    initial begin
        logic [31:0] ret_exp[5];
        rst = 1'b1;
        idle();
        tick();
        chk("reset_pc_a", pc_a, 32'h0);
        chk("reset_pc_c", 32'(pc_c), 32'h0);
        chk("reset_cnt_c", 32'(cnt_c), 32'h0);
        chk("reset_uf_c", 32'(uf_c), 32'h0);
        rst = 1'b0;

        // free-running step, byte-addressed
        for (int i = 1; i <= 5; i++) begin
            tick();
            chk($sformatf("step_pc_a_%0d", i), pc_a, 32'(4 * i));
        end

        // priority: trap beats stall and jump; stall beats jump
        jv = 1; jt = 32'h10;
        tick();
        chk("prio_setup", pc_a, 32'h10);
        trap = 1; stall = 1; jt = 32'h40;
        tick();
        chk("prio_trap", pc_a, 32'h80);
        trap = 0;
        tick();
        chk("prio_stall", pc_a, 32'h80);

        // 8-bit branch wrap both directions
        idle(); jv = 1; jt = 32'hFE;
        tick();
        chk("wrap_setup_b", 32'(pc_b), 32'hFE);
        idle(); bv = 1; bo = 32'h4;
        tick();
        chk("wrap_fwd_b", 32'(pc_b), 32'h02);
        bo = 32'hFFFF_FFFC;
        tick();
        chk("wrap_back_b", 32'(pc_b), 32'hFE);

        // call then return on the 16-bit, word-addressed instance
        idle(); trap = 1;
        tick();
        idle(); jv = 1; jt = 32'h20;
        tick();
        chk("call_setup_c", 32'(pc_c), 32'h20);
        call = 1; jt = 32'h100;
        tick();
        chk("call_pc_c", 32'(pc_c), 32'h100);
        chk("call_cnt_c", 32'(cnt_c), RAS_EN ? 32'd1 : 32'd0);
        idle(); ret = 1;
        tick();
        chk("ret_pc_c", 32'(pc_c), RAS_EN ? 32'h21 : 32'h101);
        chk("ret_cnt_c", 32'(cnt_c), 32'h0);

        // five calls into a four-deep stack, then five returns
        idle(); trap = 1;
        tick();
        for (int i = 0; i < 5; i++) begin
            idle(); jv = 1; call = 1; jt = 32'h200 + 32'(16 * i);
            tick();
        end
        chk("ovf_pc_c", 32'(pc_c), 32'h240);
        chk("ovf_cnt_c", 32'(cnt_c), RAS_EN ? 32'd4 : 32'd0);
        ret_exp = '{32'h231, 32'h221, 32'h211, 32'h201, 32'h202};
        for (int i = 0; i < 5; i++) begin
            idle(); ret = 1;
            tick();
            chk($sformatf("ovf_ret_pc_c_%0d", i), 32'(pc_c), RAS_EN ? ret_exp[i] : 32'h241 + 32'(i));
        end
        chk("udf_pulse_c", 32'(uf_c), RAS_EN ? 32'd1 : 32'd0);
        chk("udf_cnt_c", 32'(cnt_c), 32'h0);
        idle();
        tick();
        chk("udf_clear_c", 32'(uf_c), 32'h0);

        // async reset while a call is waiting for its edge
        jv = 1; call = 1; jt = 32'h300;
        tick();
        chk("arst_pre_cnt_c", 32'(cnt_c), RAS_EN ? 32'd1 : 32'd0);
        jt = 32'h340;
        #1 rst = 1'b1;
        #1;
        chk("arst_pc_a", pc_a, 32'h0);
        chk("arst_pc_c", 32'(pc_c), 32'h0);
        chk("arst_cnt_c", 32'(cnt_c), 32'h0);
        idle();
        tick();
        rst = 1'b0;
        tick();
        chk("arst_rel_pc_a", pc_a, 32'h4);
        chk("arst_rel_pc_c", 32'(pc_c), 32'h1);
        chk("arst_rel_cnt_c", 32'(cnt_c), 32'h0);

        // randomized traffic against the model
        for (int n = 0; n < 3000; n++) begin
            rst   = ($urandom_range(0, 399) == 0);
            trap  = ($urandom_range(0, 31) == 0);
            stall = ($urandom_range(0, 7) == 0);
            jv    = ($urandom_range(0, 3) == 0);
            call  = ($urandom_range(0, 1) == 0);
            ret   = ($urandom_range(0, 4) == 0);
            bv    = ($urandom_range(0, 3) == 0);
            jt    = $urandom;
            bo    = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 64)) - 32'd32 : $urandom;
            tick();
        end
        rst = 1'b0;
        idle();
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/pc_unit.md
# pc_unit

Parametrised program counter for the MIPS fetch stage. Replaces the fixed increment-only counter. Holds the fetch address and picks the next one each cycle from: trap redirect, stall hold, return, jump, PC-relative branch or sequential step. An optional return-address stack (RAS) predicts subroutine returns. It drives instruction-memory addressing directly.

## Interface
- AW, 32: PC width in bits.
- STEP, 1: sequential increment (1 = word-addressed, 4 = byte-addressed).
- RST_VEC, 0: PC value loaded on reset.
- TRAP_VEC, 'h80: PC value loaded on trap.
- RAS_DEPTH, 4: RAS entries, power of two, 2..16.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- stall  in  1  hold PC (fetch bubble)
- trap  in  1  redirect to TRAP_VEC; overrides stall
- jump_valid  in  1  absolute redirect
- jump_target  in  AW  absolute target
- branch_valid  in  1  taken PC-relative branch
- branch_off  in  AW  signed offset, added to current pc
- call  in  1  qualifies jump_valid as a call (push pc+STEP)
- ret  in  1  return (pop RAS; target = popped entry)
- pc  out  AW  registered current PC
- pc_next  out  AW  combinational value pc will take at next edge
- ras_count  out  $clog2(RAS_DEPTH)+1  valid RAS entries
- ras_underflow  out  1  registered one-cycle pulse: ret issued with RAS empty

## Operation
- Next-PC priority, highest first:
  - trap → TRAP_VEC.
  - stall → pc (hold).
  - ret with RAS non-empty → RAS top.
  - jump_valid → jump_target.
  - branch_valid → pc + branch_off.
  - Otherwise → pc + STEP.
- Arithmetic:
  - All adds are modulo 2^AW; wrap from max to 0 is silent.
  - branch_off is two's complement.
- Calls and returns:
  - call is ignored unless jump_valid=1 and the cycle is not stalled or trapped.
  - A qualified call pushes pc+STEP (modulo 2^AW).
  - Push onto a full RAS overwrites the oldest entry (circular pointer). ras_count saturates at RAS_DEPTH.
- ret on an empty RAS:
  - Falls through to the next priority level (jump, then branch, then sequential).
  - Asserts ras_underflow the next cycle.
  - ras_count stays 0.
- Simultaneous qualified call + ret: the target is the popped top. The top entry is then replaced by pc+STEP, so ras_count is unchanged. If the RAS is empty, the call applies as a normal call and underflow is flagged.
- Stall or trap: no push or pop occurs.
- Trap clears the RAS: ras_count goes to 0 at the same edge.

## Timing
- Reset (async, immediate):
  - pc=RST_VEC.
  - ras_count=0.
  - ras_underflow=0.
  - RAS contents don't-care.
- Release of rst: the first rising edge loads pc_next.
- Redirect latency: one cycle. pc reflects a redirect at the edge after its request is sampled.
- pc_next is purely combinational from pc, the inputs and the RAS top. No combinational path from pc_next back to any input.
- RAS read and update happen at the same edge as the pc update.
- rst asserted mid-operation aborts everything. A pending push or pop is lost.

## Configuration
- PC_RAS_EN defined:
  - RAS instantiated; behaviour as above.
- PC_RAS_EN undefined:
  - No RAS storage.
  - call is ignored; the jump proceeds normally.
  - ret is ignored.
  - ras_count and ras_underflow tied 0.
  - Port list unchanged.

## Structure
- Shared definitions header holds:
  - Default AW.
  - RST_VEC and TRAP_VEC constants.
  - The PC_RAS_EN switch.
- One sub-module, pc_ras: circular stack with push, pop, replace, clear, top, count and underflow.
- pc_unit holds the pc register and the next-PC mux.

## Test plan
- Reset and step: rst pulse, then 5 free cycles, AW=32, STEP=4 → pc = 0, 4, 8, 12, 16, 20.
- Priority: at pc=0x10, apply trap+stall+jump(0x40) → pc=0x80. Next cycle apply stall+jump → pc holds 0x80.
- Branch wrap: AW=8, pc=0xFE, branch_off=0x04 → pc=0x02. Then branch_off=0xFC → pc=0xFE.
- Call/return: at pc=0x20, call jump_target=0x100 → pc=0x100, ras_count=1. Then ret → pc=0x21 (STEP=1), ras_count=0.
- RAS overflow/underflow (DEPTH=4): 5 calls, then 5 rets → first 4 rets return the 4 most recent addresses. Fifth ret gives sequential pc and ras_underflow=1 for one cycle.
- Async reset mid-call: assert rst between edges while call is pending → pc=RST_VEC immediately, ras_count=0, and no push is visible after release.
